// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - Mode constants, seeds and step-period helper for the LED sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam int unsigned SEED_PATTERN = 1;
  localparam int unsigned SEED_COUNT   = 0;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Step period in clock cycles; never drops below one cycle at high speed indices.
  function automatic logic [31:0] step_period(input logic [31:0] base, input int unsigned speed);
    logic [31:0] p;
    p = base >> speed;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - Prescaler producing one tick per period; the limit is latched only on a tick.
module led_tick_gen #(
  parameter int               CNT_W       = 30,
  parameter logic [CNT_W-1:0] RESET_LIMIT = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_limit;

  assign tick_o = en_i && (r_cnt == r_limit);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt   <= '0;
      r_limit <= RESET_LIMIT;
    end else if (tick_o) begin
      r_cnt   <= '0;
      r_limit <= limit_i;
    end else if (en_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer with rotate, bounce and count modes and lap-driven speed ramp.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS      = 8,
  parameter int BASE_PERIOD = 100_000_000,
  parameter int N_SPEEDS    = 8,
  parameter int CNT_W       = 30,
  localparam int SPD_W      = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic              auto_speed_i,
  input  logic [SPD_W-1:0]  speed_i,
  output logic [N_LEDS-1:0] leds_o,
  output logic              step_o,
  output logic [SPD_W-1:0]  speed_o
);

  localparam int               LAP_W       = $clog2(N_LEDS);
  localparam logic [CNT_W-1:0] RESET_LIMIT = CNT_W'(BASE_PERIOD - 1);

  logic [N_LEDS-1:0] r_leds, w_leds_nxt, w_shl, w_shr;
  logic [1:0]        r_mode;
  dir_e              r_dir, w_dir_nxt;
  logic [LAP_W-1:0]  r_lap, w_lap_nxt;
  logic [SPD_W-1:0]  r_speed, w_speed_nxt, w_speed_in;
  logic              r_step;
  logic              w_tick, w_mode_chg, w_lap_end;
  logic [CNT_W-1:0]  w_limit_nxt;

  assign w_speed_in  = (int'(speed_i) >= N_SPEEDS) ? SPD_W'(N_SPEEDS - 1) : speed_i;
  assign w_mode_chg  = (mode_i != r_mode);
  assign w_lap_end   = (r_lap == LAP_W'(N_LEDS - 1));
  assign w_shl       = r_leds << 1;
  assign w_shr       = r_leds >> 1;
  // Limit follows the speed being registered this tick, so the new rate starts with the next period.
  assign w_limit_nxt = CNT_W'(step_period(32'(BASE_PERIOD), 32'(w_speed_nxt)) - 32'd1);

  led_tick_gen #(
    .CNT_W       (CNT_W),
    .RESET_LIMIT (RESET_LIMIT)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .limit_i (w_limit_nxt),
    .tick_o  (w_tick)
  );

  always_comb begin
    w_leds_nxt  = r_leds;
    w_dir_nxt   = r_dir;
    w_lap_nxt   = r_lap;
    w_speed_nxt = r_speed;
    if (w_tick) begin
      if (w_mode_chg) begin
        w_leds_nxt = (mode_i == MODE_COUNT) ? N_LEDS'(SEED_COUNT) : N_LEDS'(SEED_PATTERN);
        w_dir_nxt  = DIR_LEFT;
        w_lap_nxt  = '0;
      end else begin
        w_lap_nxt = w_lap_end ? '0 : r_lap + LAP_W'(1);
        case (r_mode)
          MODE_ROL: w_leds_nxt = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
          MODE_ROR: w_leds_nxt = {r_leds[0], r_leds[N_LEDS-1:1]};
          MODE_BOUNCE: begin
            if (r_dir == DIR_LEFT) begin
              w_leds_nxt = w_shl;
              if (w_shl[N_LEDS-1]) w_dir_nxt = DIR_RIGHT;
            end else begin
              w_leds_nxt = w_shr;
              if (w_shr[0]) w_dir_nxt = DIR_LEFT;
            end
          end
          default: w_leds_nxt = r_leds + N_LEDS'(1);
        endcase
        if (auto_speed_i && w_lap_end)
          w_speed_nxt = (r_speed == SPD_W'(N_SPEEDS - 1)) ? '0 : r_speed + SPD_W'(1);
      end
      if (!auto_speed_i) w_speed_nxt = w_speed_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_leds  <= N_LEDS'(SEED_PATTERN);
      r_mode  <= MODE_ROL;
      r_dir   <= DIR_LEFT;
      r_lap   <= '0;
      r_speed <= '0;
      r_step  <= 1'b0;
    end else begin
      r_leds  <= w_leds_nxt;
      r_mode  <= w_tick ? mode_i : r_mode;
      r_dir   <= w_dir_nxt;
      r_lap   <= w_lap_nxt;
      r_speed <= w_speed_nxt;
      r_step  <= w_tick;
    end
  end

  assign leds_o  = r_leds;
  assign step_o  = r_step;
  assign speed_o = r_speed;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - Self-checking bench: step-index model of the LED sequencer plus directed sequences.
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int BP = 8;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, auto_spd;
  logic [1:0]   mode, spd_in;
  logic [N-1:0] leds;
  logic         step;
  logic [1:0]   spd;

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS      (N),
    .BASE_PERIOD (BP),
    .N_SPEEDS    (NS),
    .CNT_W       (30)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .mode_i       (mode),
    .auto_speed_i (auto_spd),
    .speed_i      (spd_in),
    .leds_o       (leds),
    .step_o       (step),
    .speed_o      (spd)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int m_mode, m_s, m_speed, m_elapsed, m_period;
  bit m_step;
  logic [N-1:0] log_leds[$];
  int           log_cyc[$];
  logic [1:0]   log_spd[$];
  int           exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int period_of(input int s);
    int p = BP >> s;
    return (p < 1) ? 1 : p;
  endfunction

  // Pattern as a function of steps taken since the last seed.
  function automatic logic [N-1:0] exp_leds(input int md, input int s);
    int r;
    case (md)
      0: return N'(1 << (s % N));
      1: return N'(1 << ((N - s % N) % N));
      2: begin
        r = s % (2 * N - 2);
        return N'(1 << ((r < N) ? r : 2 * N - 2 - r));
      end
      default: return N'(s % (1 << N));
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_s = 0; m_speed = 0; m_elapsed = 0; m_period = BP; m_step = 1'b0;
  endtask

  task automatic m_advance();
    m_step = 1'b0;
    if (en) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        m_step = 1'b1;
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_s = 0;
        end else begin
          m_s++;
          if (auto_spd && (m_s % N == 0)) m_speed = (m_speed + 1) % NS;
        end
        if (!auto_spd) m_speed = (int'(spd_in) >= NS) ? NS - 1 : int'(spd_in);
        m_period = period_of(m_speed);
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) m_advance(); else m_reset();
      @(negedge clk);
      if (!rst_n) m_reset();
      check("leds", leds, exp_leds(m_mode, m_s));
      check("step", step, m_step);
      check("speed", spd, m_speed);
      if (step === 1'b1) begin
        log_leds.push_back(leds);
        log_cyc.push_back(cyc);
        log_spd.push_back(spd);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    log_leds.delete();
    log_cyc.delete();
    log_spd.delete();
  endtask

  task automatic do_reset(input bit a, input logic [1:0] md);
    rst_n = 1'b0; en = 1'b1; auto_spd = a; mode = md; spd_in = 2'd0;
    cyc_wait(2);
    clear_log();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_steps(input int n, input int budget, input string name);
    int k = 0;
    while (log_leds.size() < n && k < budget) begin
      cyc_wait(1);
      k++;
    end
    if (log_leds.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d steps expected %0d", name, log_leds.size(), n);
    end
  endtask

  task automatic check_log(input string name);
    foreach (exp_q[i]) check($sformatf("%s[%0d]", name, i), 32'(log_leds[i]), exp_q[i]);
  endtask

  task automatic check_gaps(input string name);
    int prev = rel_cyc;
    foreach (exp_q[i]) begin
      check($sformatf("%s_gap[%0d]", name, i), log_cyc[i] - prev, exp_q[i]);
      prev = log_cyc[i];
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; en = 1'b0; auto_spd = 1'b0; mode = 2'd0; spd_in = 2'd0;
    cyc_wait(2);
    check("rst_leds", leds, 1);
    check("rst_step", step, 0);
    check("rst_speed", spd, 0);

    do_reset(1'b0, 2'd0);
    wait_steps(4, 100, "rol");
    exp_q = {2, 4, 8, 1};       check_log("rol");
    exp_q = {8, 8, 8, 8};       check_gaps("rol");

    do_reset(1'b0, 2'd2);
    wait_steps(8, 120, "bounce");
    exp_q = {1, 2, 4, 8, 4, 2, 1, 2}; check_log("bounce");

    do_reset(1'b0, 2'd1);
    spd_in = 2'd2;
    wait_steps(4, 100, "ror");
    exp_q = {1, 8, 4, 2};       check_log("ror");
    exp_q = {8, 2, 2, 2};       check_gaps("ror");
    check("ror_speed", 32'(log_spd[0]), 2);

    do_reset(1'b0, 2'd0);
    wait_steps(1, 50, "pre_count");
    cyc_wait(3);
    mode = 2'd3;
    clear_log();
    wait_steps(17, 300, "count");
    exp_q = {0, 1, 2, 3};       check_log("count");
    check("count_15", 32'(log_leds[15]), 15);
    check("count_wrap", 32'(log_leds[16]), 0);

    do_reset(1'b0, 2'd0);
    wait_steps(1, 50, "pre_en");
    cyc_wait(3);
    en = 1'b0;
    cyc_wait(20);
    check("en_hold_steps", log_leds.size(), 1);
    en = 1'b1;
    c0 = cyc;
    wait_steps(2, 50, "en_resume");
    check("en_resume_delay", log_cyc[1] - c0, 5);

    do_reset(1'b1, 2'd0);
    wait_steps(17, 200, "auto");
    exp_q = {8, 8, 8, 8, 4, 4, 4, 4, 2, 2, 2, 2, 1, 1, 1, 1, 8};
    check_gaps("auto");
    check("auto_spd3", 32'(log_spd[3]), 1);
    check("auto_spd11", 32'(log_spd[11]), 3);
    check("auto_spd15", 32'(log_spd[15]), 0);

    do_reset(1'b1, 2'd0);
    wait_steps(10, 200, "pre_async");
    cyc_wait(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_leds", leds, 1);
    check("async_speed", spd, 0);
    check("async_step", step, 0);
    cyc_wait(1);
    auto_spd = 1'b0;
    clear_log();
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_steps(1, 50, "post_async");
    check("post_async_first", log_cyc[0] - rel_cyc, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
